// File: rtl/wb_slave_decode.sv
// wb_slave_decode: Wishbone address decoder and response mux for up to 8 register slaves.
// Master side: wb_cyc_i/wb_stb_i/wb_we_i/wb_sel_i/wb_adr_i/wb_dat_i in, wb_dat_o/wb_ack_o/wb_err_o out.
// Slave side: per-slave s_cyc_o/s_stb_o (one-hot or zero), broadcast s_we_o/s_sel_o/s_adr_o/s_dat_o,
// packed s_dat_i plus per-slave s_ack_i/s_err_i in. wb_rst_i is asynchronous and active-low.
module wb_slave_decode #(
  parameter int           C_NUM_SLAVES = 4,
  parameter logic [255:0] C_SLAVE_BASE = '0,
  parameter logic [255:0] C_SLAVE_HIGH = '0,
  parameter int           C_TIMEOUT    = 255
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       wb_cyc_i,
  input  logic                       wb_stb_i,
  input  logic                       wb_we_i,
  input  logic [3:0]                 wb_sel_i,
  input  logic [31:0]                wb_adr_i,
  input  logic [31:0]                wb_dat_i,
  output logic [31:0]                wb_dat_o,
  output logic                       wb_ack_o,
  output logic                       wb_err_o,
  output logic [C_NUM_SLAVES-1:0]    s_cyc_o,
  output logic [C_NUM_SLAVES-1:0]    s_stb_o,
  output logic                       s_we_o,
  output logic [3:0]                 s_sel_o,
  output logic [31:0]                s_adr_o,
  output logic [31:0]                s_dat_o,
  input  logic [32*C_NUM_SLAVES-1:0] s_dat_i,
  input  logic [C_NUM_SLAVES-1:0]    s_ack_i,
  input  logic [C_NUM_SLAVES-1:0]    s_err_i
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t                  state_q, state_d;
  logic [C_NUM_SLAVES-1:0] stb_q, stb_d, hit_oh;
  logic                    we_q, we_d, ack_q, ack_d, err_q, err_d;
  logic [3:0]              sel_q, sel_d;
  logic [31:0]             adr_q, adr_d, wdat_q, wdat_d, rdat_q, rdat_d, sel_dat;
  logic [15:0]             cnt_q, cnt_d;
  logic                    sel_ack, sel_err, tmo;
  // Scan from the top index down so the lowest matching window ends up selected.
  always_comb begin
    hit_oh = '0;
    for (int k = C_NUM_SLAVES-1; k >= 0; k--)
      if (C_SLAVE_BASE[32*k +: 32] <= wb_adr_i && wb_adr_i <= C_SLAVE_HIGH[32*k +: 32]) begin
        hit_oh    = '0;
        hit_oh[k] = 1'b1;
      end
  end
  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < C_NUM_SLAVES; k++)
      if (stb_q[k]) sel_dat = s_dat_i[32*k +: 32];
  end
  // Masking with the active strobe ignores responses from slaves that were not addressed.
  assign sel_ack = |(s_ack_i & stb_q);
  assign sel_err = |(s_err_i & stb_q);
  assign tmo     = (C_TIMEOUT != 0) && (cnt_q == 16'(C_TIMEOUT - 1));
  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (wb_cyc_i && wb_stb_i) begin
        we_d    = wb_we_i;
        sel_d   = wb_sel_i;
        adr_d   = wb_adr_i;
        wdat_d  = wb_dat_i;
        stb_d   = hit_oh;
        cnt_d   = '0;
        err_d   = ~|hit_oh;
        state_d = |hit_oh ? BUSY : RESP;
      end
      BUSY: begin
        cnt_d = cnt_q + 16'd1;
        if (!wb_cyc_i) begin
          stb_d   = '0;
          state_d = IDLE;
        end else if (sel_err) begin
          err_d   = 1'b1;
          rdat_d  = '0;
          stb_d   = '0;
          state_d = RESP;
        end else if (sel_ack) begin
          ack_d   = 1'b1;
          rdat_d  = sel_dat;
          stb_d   = '0;
          state_d = RESP;
        end else if (tmo) begin
          err_d   = 1'b1;
          stb_d   = '0;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      stb_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end
  assign s_cyc_o  = stb_q;
  assign s_stb_o  = stb_q;
  assign s_we_o   = we_q;
  assign s_sel_o  = sel_q;
  assign s_adr_o  = adr_q;
  assign s_dat_o  = wdat_q;
  assign wb_dat_o = rdat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
endmodule

// File: tb/tb_wb_slave_decode.sv
// tb_wb_slave_decode: directed checks of decode, response mux, timeout, abort and reset.
module tb_wb_slave_decode;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, wdat = '0;
  logic [31:0] rdat;
  logic        ack, err;
  logic [1:0]  s_cyc, s_stb, s_ack = '0, s_err = '0;
  logic        s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat;
  logic [63:0] s_rdat = '0;
  int          total = 0, bad = 0;
  always #5 clk = ~clk;
  wb_slave_decode #(
    .C_NUM_SLAVES(2),
    .C_SLAVE_BASE({192'h0, 32'h10, 32'h00}),
    .C_SLAVE_HIGH({192'h0, 32'h1F, 32'h0F}),
    .C_TIMEOUT(8)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat), .wb_ack_o(ack),
    .wb_err_o(err), .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
  endtask
  task automatic idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask
  initial begin
    req(1'b0, 32'h14, 32'h0, 4'hF);
    tick(); tick();
    chk("rst_stb", 32'(s_stb), 32'h0);
    chk("rst_cyc", 32'(s_cyc), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_dat", rdat, 32'h0);
    chk("rst_adr", s_adr, 32'h0);
    idle();
    rst_n = 1'b1;
    tick();
    // read hit on slave1, slave acks one cycle after strobe
    req(1'b0, 32'h14, 32'h0, 4'hF);
    tick();
    chk("rd_stb_e0", 32'(s_stb), 32'h2);
    chk("rd_cyc_e0", 32'(s_cyc), 32'h2);
    chk("rd_ack_e0", 32'(ack), 32'h0);
    tick();
    chk("rd_stb_e1", 32'(s_stb), 32'h2);
    s_ack = 2'b10; s_rdat = {32'hDEADBEEF, 32'h0};
    tick();
    chk("rd_ack_e2", 32'(ack), 32'h1);
    chk("rd_dat_e2", rdat, 32'hDEADBEEF);
    chk("rd_stb_e2", 32'(s_stb), 32'h0);
    s_ack = '0; idle();
    tick();
    chk("rd_ack_e3", 32'(ack), 32'h0);
    chk("rd_dat_hold", rdat, 32'hDEADBEEF);
    tick();
    // write broadcast to slave0
    s_rdat = {32'hDEADBEEF, 32'hDEADBEEF};
    req(1'b1, 32'h04, 32'h12345678, 4'b0011);
    tick();
    chk("wr_stb", 32'(s_stb), 32'h1);
    chk("wr_adr", s_adr, 32'h04);
    chk("wr_dat", s_wdat, 32'h12345678);
    chk("wr_sel", 32'(s_sel), 32'h3);
    chk("wr_we", 32'(s_we), 32'h1);
    s_ack = 2'b01;
    tick();
    chk("wr_ack", 32'(ack), 32'h1);
    chk("wr_err", 32'(err), 32'h0);
    s_ack = '0; idle();
    tick();
    chk("wr_ack_off", 32'(ack), 32'h0);
    tick();
    // decode miss
    req(1'b0, 32'h100, 32'h0, 4'hF);
    tick();
    chk("miss_stb", 32'(s_stb), 32'h0);
    chk("miss_err", 32'(err), 32'h1);
    chk("miss_ack", 32'(ack), 32'h0);
    idle();
    tick();
    chk("miss_err_off", 32'(err), 32'h0);
    chk("miss_ack_off", 32'(ack), 32'h0);
    chk("miss_dat_hold", rdat, 32'hDEADBEEF);
    tick();
    // timeout on slave0, then a late ack is ignored
    req(1'b0, 32'h08, 32'h0, 4'hF);
    tick();
    chk("to_stb", 32'(s_stb), 32'h1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("to_wait%0d_err", i), 32'(err), 32'h0);
      chk($sformatf("to_wait%0d_stb", i), 32'(s_stb), 32'h1);
    end
    tick();
    chk("to_err", 32'(err), 32'h1);
    chk("to_stb_off", 32'(s_stb), 32'h0);
    chk("to_ack", 32'(ack), 32'h0);
    idle(); s_ack = 2'b01;
    tick();
    chk("late_err", 32'(err), 32'h0);
    chk("late_ack1", 32'(ack), 32'h0);
    tick();
    chk("late_ack2", 32'(ack), 32'h0);
    s_ack = '0;
    tick();
    // master abort in BUSY
    req(1'b0, 32'h18, 32'h0, 4'hF);
    tick();
    chk("ab_stb_on", 32'(s_stb), 32'h2);
    idle();
    tick();
    chk("ab_stb_off", 32'(s_stb), 32'h0);
    chk("ab_ack", 32'(ack), 32'h0);
    chk("ab_err", 32'(err), 32'h0);
    tick();
    chk("ab_ack2", 32'(ack), 32'h0);
    chk("ab_err2", 32'(err), 32'h0);
    // ack and err together: err wins, data cleared
    req(1'b0, 32'h18, 32'h0, 4'hF);
    tick();
    s_ack = 2'b10; s_err = 2'b10; s_rdat = {32'h5555AAAA, 32'h0};
    tick();
    chk("ae_err", 32'(err), 32'h1);
    chk("ae_ack", 32'(ack), 32'h0);
    chk("ae_dat", rdat, 32'h0);
    s_ack = '0; s_err = '0; idle();
    tick();
    chk("ae_err_off", 32'(err), 32'h0);
    tick();
    // responses from the non-selected slave are ignored
    req(1'b0, 32'h1C, 32'h0, 4'hF);
    tick();
    s_ack = 2'b01; s_err = 2'b01; s_rdat = {32'hCAFEF00D, 32'h11111111};
    tick();
    chk("ns_ack", 32'(ack), 32'h0);
    chk("ns_err", 32'(err), 32'h0);
    chk("ns_stb", 32'(s_stb), 32'h2);
    s_ack = 2'b10; s_err = '0;
    tick();
    chk("ns_ack_ok", 32'(ack), 32'h1);
    chk("ns_dat", rdat, 32'hCAFEF00D);
    s_ack = '0; idle();
    tick(); tick();
    // asynchronous reset mid-transaction
    req(1'b0, 32'h10, 32'h0, 4'hF);
    tick();
    chk("mr_stb_on", 32'(s_stb), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_stb_off", 32'(s_stb), 32'h0);
    chk("mr_dat", rdat, 32'h0);
    chk("mr_adr", s_adr, 32'h0);
    s_ack = 2'b10;
    tick();
    chk("mr_ack", 32'(ack), 32'h0);
    s_ack = '0; idle();
    rst_n = 1'b1;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
